// File: rtl/alu_issue_unit_if.sv
// Instruction/ALU/debug bundle between the sequencer, the issue unit and the external ALU.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready handshake on the instruction side only.
interface alu_issue_unit_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [DATA_WIDTH-1:0] alu_rs1;
    logic [DATA_WIDTH-1:0] alu_rs2;
    logic [3:0]            alu_func3;
    logic [3:0]            alu_func7;
    logic [DATA_WIDTH-1:0] alu_c;
    logic                  done;
    logic                  err;
    logic [4:0]            dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;

    modport master (
        output in_valid, in_instr, alu_c, dbg_addr,
        input  in_ready, alu_rs1, alu_rs2, alu_func3, alu_func7, done, err, dbg_data
    );

    modport slave (
        input  in_valid, in_instr, alu_c, dbg_addr,
        output in_ready, alu_rs1, alu_rs2, alu_func3, alu_func7, done, err, dbg_data
    );
endinterface

// File: rtl/alu_issue_unit.sv
// RV64 OP/OP-IMM decode, register-file read, ALU operand issue and rd writeback.
// Latency: accept at N, ALU operands valid N+1, writeback/done at N+2; err at N+1.
// Backpressure: in_ready only in IDLE, so one instruction in flight at a time.
module alu_issue_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_unit_if.slave   bus
);
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

    typedef struct packed {
        logic                  legal;
        logic [DATA_WIDTH-1:0] op_a;
        logic [DATA_WIDTH-1:0] op_b;
        logic [3:0]            func3;
        logic [3:0]            func7;
        logic [4:0]            rd;
    } dec_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            rd_q;
    dec_t                  dec;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] shamt_imm;
    logic [DATA_WIDTH-1:0] shamt_reg;

    assign opcode    = bus.in_instr[6:0];
    assign funct3    = bus.in_instr[14:12];
    assign funct7    = bus.in_instr[31:25];
    assign rs1       = bus.in_instr[19:15];
    assign rs2       = bus.in_instr[24:20];
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign rs1_val   = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val   = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign imm_sext  = {{(DATA_WIDTH-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign shamt_imm = {{(DATA_WIDTH-SHW){1'b0}}, bus.in_instr[20 +: SHW]};
    assign shamt_reg = {{(DATA_WIDTH-SHW){1'b0}}, rs2_val[SHW-1:0]};

    assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];

    always_comb begin
        dec       = '0;
        dec.op_a  = rs1_val;
        dec.func3 = {1'b0, funct3};
        dec.rd    = bus.in_instr[11:7];
        case (opcode)
            7'b0110011: begin
                dec.legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.op_b  = is_shift ? shamt_reg : rs2_val;
                dec.func7 = (funct7 == 7'b0100000) ? 4'b0100 : 4'b0000;
            end
            7'b0010011: begin
                dec.op_b = is_shift ? shamt_imm : imm_sext;
                // Only the right shifts honour instr[30]; ADDI etc. never become SUB.
                case (funct3)
                    3'b001:  dec.legal = (bus.in_instr[31:26] == 6'b000000);
                    3'b101:  dec.legal = (bus.in_instr[31:26] == 6'b000000) ||
                                         (bus.in_instr[31:26] == 6'b010000);
                    default: dec.legal = 1'b1;
                endcase
                dec.func7 = ((funct3 == 3'b101) && bus.in_instr[30]) ? 4'b0100 : 4'b0000;
            end
            default: dec.legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.alu_rs1   <= '0;
            bus.alu_rs2   <= '0;
            bus.alu_func3 <= '0;
            bus.alu_func7 <= '0;
            rd_q          <= '0;
            result        <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (dec.legal) begin
                            bus.alu_rs1   <= dec.op_a;
                            bus.alu_rs2   <= dec.op_b;
                            bus.alu_func3 <= dec.func3;
                            bus.alu_func7 <= dec.func7;
                            rd_q          <= dec.rd;
                            state         <= EXEC;
                        end else begin
                            bus.err <= 1'b1;
                            state   <= ERR;
                        end
                    end
                end
                EXEC: begin
                    result   <= bus.alu_c;
                    bus.done <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    if (rd_q != 5'd0) begin
                        regs[rd_q] <= result;
                    end
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: ISA-level reference model plus per-cycle compare.
// Latency: n/a. Backpressure: the driver waits for the model to return to idle.
// The bench also plays the role of the external combinational ALU.
module tb_alu_issue_unit;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_unit_if #(.DATA_WIDTH(DW)) bus();

    alu_issue_unit #(.DATA_WIDTH(DW), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] alu_fn(input logic [2:0] f3, input logic alt,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[5:0];
            3'd2:    r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3:    r = (a < b) ? 64'd1 : 64'd0;
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign bus.alu_c = alu_fn(bus.alu_func3[2:0], bus.alu_func7[2], bus.alu_rs1, bus.alu_rs2);

    // Reference model: architectural registers and a phase counter since accept.
    logic [63:0] mregs [32];
    int          ph = 0;
    logic        m_legal = 1'b0;
    logic        m_alt;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [63:0] m_a, m_b;
    logic [31:0] ins;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        end else begin
            case (ph)
                0: if (bus.in_valid) begin
                    ins  = bus.in_instr;
                    m_f3 = ins[14:12];
                    m_rd = ins[11:7];
                    m_a  = mregs[ins[19:15]];
                    if (ins[6:0] == 7'h33) begin
                        m_b     = mregs[ins[24:20]];
                        m_alt   = (ins[31:25] == 7'h20);
                        m_legal = (ins[31:25] == 7'h00) || (m_alt && (m_f3 == 3'd0 || m_f3 == 3'd5));
                        if (m_f3 == 3'd1 || m_f3 == 3'd5) m_b = m_b % 64;
                    end else if (ins[6:0] == 7'h13) begin
                        m_b     = {{52{ins[31]}}, ins[31:20]};
                        m_alt   = 1'b0;
                        m_legal = 1'b1;
                        if (m_f3 == 3'd1) begin
                            m_legal = (ins[31:26] == 6'h00);
                            m_b     = 64'(ins[25:20]);
                        end
                        if (m_f3 == 3'd5) begin
                            m_legal = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h10);
                            m_alt   = ins[30];
                            m_b     = 64'(ins[25:20]);
                        end
                    end else begin
                        m_legal = 1'b0;
                    end
                    ph = 1;
                end
                1: ph = m_legal ? 2 : 0;
                default: begin
                    if (m_rd != 5'd0) mregs[m_rd] = alu_fn(m_f3, m_alt, m_a, m_b);
                    ph = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, 64'(ph == 0));
        chk("done", bus.done, 64'(ph == 2));
        chk("err", bus.err, 64'(ph == 1 && !m_legal));
        if (ph == 1 && m_legal) begin
            chk("alu_rs1", bus.alu_rs1, m_a);
            chk("alu_rs2", bus.alu_rs2, m_b);
            chk("alu_func3", bus.alu_func3, {61'd0, m_f3});
            chk("alu_func7", bus.alu_func7, m_alt ? 64'd4 : 64'd0);
        end
        if (!rst_n) begin
            chk("rst_alu_rs1", bus.alu_rs1, 64'd0);
            chk("rst_alu_func7", bus.alu_func7, 64'd0);
        end
        chk("dbg_data", bus.dbg_data, mregs[bus.dbg_addr]);
    end

    task automatic issue(input logic [31:0] instr, input bit lit,
                         input logic [3:0] f7, input logic [63:0] rs2);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        if (lit) begin
            chk("lit_func7", bus.alu_func7, 64'(f7));
            chk("lit_rs2", bus.alu_rs2, rs2);
        end
        for (int i = 0; i < 8 && ph != 0; i++) begin
            @(posedge clk); #2;
        end
        chk("drain", 64'(ph == 0), 64'd1);
    endtask

    task automatic check_reg(input logic [4:0] addr, input logic [63:0] val);
        bus.dbg_addr = addr;
        #1;
        chk("reg", bus.dbg_data, val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.dbg_addr = 5'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", bus.in_ready, 64'd1);
        chk("rst_done", bus.done, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        issue(32'h00500093, 1, 4'h0, 64'd5);                      // ADDI x1,x0,5
        check_reg(5'd1, 64'd5);
        issue(32'hFFD00113, 1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFD);    // ADDI x2,x0,-3
        issue(32'h402081B3, 1, 4'h4, 64'hFFFF_FFFF_FFFF_FFFD);    // SUB x3,x1,x2
        check_reg(5'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        check_reg(5'd3, 64'd8);
        issue(32'h40000213, 1, 4'h0, 64'h400);                    // ADDI x4,x0,0x400
        check_reg(5'd4, 64'h400);
        issue(32'h40115293, 1, 4'h4, 64'd1);                      // SRAI x5,x2,1
        check_reg(5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(32'h04100393, 0, 4'h0, 64'd0);                      // ADDI x7,x0,65
        issue(32'h00709333, 1, 4'h0, 64'd1);                      // SLL x6,x1,x7
        check_reg(5'd6, 64'd10);
        issue(32'h00700013, 0, 4'h0, 64'd0);                      // ADDI x0,x0,7
        check_reg(5'd0, 64'd0);
        issue(32'h00309413, 0, 4'h0, 64'd0);                      // SLLI x8,x1,3
        check_reg(5'd8, 64'd40);
        issue(32'h001154B3, 0, 4'h0, 64'd0);                      // SRL x9,x2,x1
        check_reg(5'd9, 64'h07FF_FFFF_FFFF_FFFF);
        issue(32'h0000006F, 0, 4'h0, 64'd0);                      // JAL: illegal
        issue(32'h40209333, 0, 4'h0, 64'd0);                      // SUB-form funct3=001: illegal
        check_reg(5'd6, 64'd10);
        check_reg(5'd1, 64'd5);

        // Reset while ADDI x1,x0,9 is in EXEC.
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00900093;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("rst_mid_done", bus.done, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_reg(5'd1, 64'd0);
        chk("post_rst_in_ready", bus.in_ready, 64'd1);
        repeat (4) @(posedge clk);
        #2;
        check_reg(5'd1, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Instruction-side counterpart of the 64-bit integer ALU: accepts one RV64 OP/OP-IMM instruction per handshake and decodes it.
- Reads operands from an internal 32-entry register file and drives registered operands and function codes into the ALU.
- Captures the ALU result and writes it back to rd.
- Sits between the fetch/sequencer and the ALU; the ALU itself is external and purely combinational.

Parameters:
- DATA_WIDTH, 64, register and operand width; shift amounts use the low log2(DATA_WIDTH) bits.
- NUM_REGS, 32, register file depth; entry 0 is hardwired zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  unit can accept an instruction.
- in_instr  input  32  RV64 instruction word.
- alu_rs1  output  DATA_WIDTH  operand A to ALU (data_rs1).
- alu_rs2  output  DATA_WIDTH  operand B to ALU (data_rs2).
- alu_func3  output  4  ALU op select; {1'b0, funct3}.
- alu_func7  output  4  4'b0000 normal; 4'b0100 alternate (SUB/SRA).
- alu_c  input  DATA_WIDTH  ALU result.
- done  output  1  one-cycle pulse: writeback cycle of a legal instruction.
- err  output  1  one-cycle pulse: illegal instruction dropped.
- dbg_addr  input  5  debug register select.
- dbg_data  output  DATA_WIDTH  combinational register file read; 0 for addr 0.

Behaviour:
- Reset is asynchronous and active-low; while rst_n=0:
  - state = IDLE;
  - all registers cleared to 0;
  - alu_rs1, alu_rs2, alu_func3, alu_func7 = 0;
  - done = 0, err = 0.
  - in_ready = (state==IDLE), so it is 1 from the first cycle after reset release.
- FSM states: IDLE, EXEC, WB, ERR.
- IDLE: in_ready=1. When in_valid=1, the instruction is accepted at that edge (cycle N); decode and register-file read happen combinationally and are registered into the alu_* outputs and an rd latch.
  - Legal instruction -> EXEC.
  - Illegal instruction -> ERR.
  - When in_valid=0, hold all outputs.
- EXEC (N+1): alu_* outputs stable; alu_c is sampled into a result register at the closing edge -> WB.
- WB (N+2): done=1; at the closing edge the result register is written to rd -> IDLE. rd=0 gives no write, but done is still asserted.
- ERR (N+1): err=1, no register write, alu_* outputs unchanged -> IDLE.
- in_ready=0 in EXEC/WB/ERR; the earliest next accept is N+3 (legal) or N+2 (illegal).
- No hazards are possible: a dependent instruction accepted in the cycle after WB reads the updated value.
- OP (opcode 0110011):
  - alu_rs1=R[rs1], alu_rs2=R[rs2].
  - Legal funct7 values: 0000000 with any funct3; 0100000 only with funct3 000 or 101. Anything else is illegal.
  - alu_func7=4'b0100 iff funct7=0100000.
- OP-IMM (opcode 0010011):
  - alu_rs1=R[rs1], alu_rs2=sign-extended instr[31:20].
  - alu_func7=0000 for every funct3 except 101.
  - ADDI/SLTI/etc. never select SUB, whatever instr[30] is.
  - SLLI: instr[31:26] must be 000000, else illegal.
  - SRLI/SRAI: instr[31:26] must be 000000 or 010000; instr[30] selects SRA (func7=0100).
  - For shifts, alu_rs2 = zero-extended shamt instr[25:20].
- Shifts (SLL/SRL/SRA and the immediate forms): alu_rs2 upper bits are forced to 0, keeping only rs2[5:0] for R-type.
- Any other opcode is illegal.
- Register file: R[0] reads 0 always; writes to R[0] are ignored.
- The result register is DATA_WIDTH wide and stored without modification; the ALU flag outputs are not used.
- Reset asserted mid-EXEC/WB: the in-flight instruction is discarded, no write occurs, and the register file is cleared.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) -> in_ready=0 for 2 cycles; alu_func3=0, alu_func7=0, alu_rs2=5; done in N+2; dbg x1=5.
- ADDI x2,x0,-3, then SUB x3,x1,x2 -> x2=0xFFFF_FFFF_FFFF_FFFD; SUB shows alu_func7=4'b0100, alu_rs1=5, alu_rs2=x2; x3=8.
- ADDI x4,x0,0x400 (instr[30]=1) -> alu_func7=0000, x4=0x400; SRAI x5,x2,1 -> alu_func7=0100, alu_rs2=1.
- x7=65; SLL x6,x1,x7 -> alu_rs2=1, x6=10; ADDI x0,x0,7 -> done=1, dbg x0=0.
- JAL word 0x0000006F and SUB-form with funct3=001 -> err pulse in N+1, in_ready back in N+2, all registers unchanged.
- Assert rst_n=0 during EXEC of ADDI x1,x0,9 -> no done; after release x1=0 and in_ready=1.
